servo_pwm_driver: RTL and testbench

Two-axis hobby-servo PWM generator and the actuator end of the tracker's base/arm angle outputs. It accepts 9-bit angle commands for the base and arm axes and slews each axis toward its target by a bounded step per PWM frame. It produces one standard servo pulse per frame on each axis and flags when both axes have held their targets for a full frame.

---
 rtl/servo_pwm_driver.sv | 89 ++++++++
 tb/tb_servo_pwm_driver.sv | 173 +++++++++++++++++
 2 files changed

// File: rtl/servo_pwm_driver.sv
// servo_pwm_driver: two-axis servo PWM generator with per-frame slew limiting and a settled flag.
module servo_pwm_driver #(
  parameter int TICKS_PER_US = 50,
  parameter int PERIOD_US    = 20000,
  parameter int MIN_US       = 600,
  parameter int STEP_US      = 10,
  parameter int MAX_DEG      = 180,
  parameter int HOME_DEG     = 90,
  parameter int SLEW_DEG     = 5
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [8:0] base_angle,
  input  logic [8:0] arm_angle,
  input  logic       cmd_valid,
  output logic       base_pwm,
  output logic       arm_pwm,
  output logic [8:0] base_cur,
  output logic [8:0] arm_cur,
  output logic       settled
);
  localparam int PW = TICKS_PER_US > 1 ? $clog2(TICKS_PER_US) : 1;
  localparam int UW = $clog2(PERIOD_US);
  localparam logic signed [9:0] SL = 10'(SLEW_DEG);
  logic [PW-1:0] r_pre;
  logic [UW-1:0] r_us;
  logic r_run, r_settled, r_dirty;
  logic [8:0] r_base_tgt, r_arm_tgt, r_base_cur, r_arm_cur;
  logic w_tick, w_fe, w_chg, w_diff, w_match;
  logic [8:0] w_base_cl, w_arm_cl;
  logic [UW-1:0] w_base_w, w_arm_w;
  function automatic logic [8:0] clamp(input logic [8:0] a);
    return a > 9'(MAX_DEG) ? 9'(MAX_DEG) : a;
  endfunction
  function automatic logic [8:0] slew(input logic [8:0] cur, input logic [8:0] tgt);
    logic signed [9:0] d;
    d = $signed({1'b0, tgt}) - $signed({1'b0, cur});
    return (SLEW_DEG == 0 || (d <= SL && d >= -SL)) ? tgt :
           d[9] ? cur - 9'(SLEW_DEG) : cur + 9'(SLEW_DEG);
  endfunction
  // r_run holds the timebase at zero for one cycle so the first frame starts cleanly after reset
  assign w_tick    = r_pre == PW'(TICKS_PER_US - 1);
  assign w_fe      = r_run && w_tick && r_us == UW'(PERIOD_US - 1);
  assign w_base_cl = clamp(base_angle);
  assign w_arm_cl  = clamp(arm_angle);
  assign w_chg     = cmd_valid && (w_base_cl != r_base_tgt || w_arm_cl != r_arm_tgt);
  assign w_diff    = cmd_valid && (w_base_cl != r_base_cur || w_arm_cl != r_arm_cur);
  assign w_match   = r_base_cur == r_base_tgt && r_arm_cur == r_arm_tgt;
  assign w_base_w  = UW'(MIN_US) + UW'(r_base_cur) * UW'(STEP_US);
  assign w_arm_w   = UW'(MIN_US) + UW'(r_arm_cur) * UW'(STEP_US);
  assign base_pwm  = r_run && r_us < w_base_w;
  assign arm_pwm   = r_run && r_us < w_arm_w;
  assign base_cur  = r_base_cur;
  assign arm_cur   = r_arm_cur;
  assign settled   = r_settled;
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_run      <= 1'b0;
      r_pre      <= '0;
      r_us       <= '0;
      r_base_tgt <= 9'(HOME_DEG);
      r_arm_tgt  <= 9'(HOME_DEG);
      r_base_cur <= 9'(HOME_DEG);
      r_arm_cur  <= 9'(HOME_DEG);
      r_settled  <= 1'b0;
      r_dirty    <= 1'b0;
    end else begin
      r_run <= 1'b1;
      if (r_run) begin
        r_pre <= w_tick ? '0 : r_pre + PW'(1);
        if (w_tick) r_us <= w_fe ? '0 : r_us + UW'(1);
      end
      if (cmd_valid) begin
        r_base_tgt <= w_base_cl;
        r_arm_tgt  <= w_arm_cl;
      end
      // slew and settle decisions use the targets that were in force during the ending frame
      if (w_fe) begin
        r_base_cur <= slew(r_base_cur, r_base_tgt);
        r_arm_cur  <= slew(r_arm_cur, r_arm_tgt);
        r_settled  <= w_match && !r_dirty && !w_chg && !w_diff;
        r_dirty    <= 1'b0;
      end else begin
        r_settled <= r_settled && !w_diff;
        r_dirty   <= r_dirty || w_chg;
      end
    end
  end
endmodule

// File: tb/tb_servo_pwm_driver.sv
// tb_servo_pwm_driver: directed checks of timebase, slew, clamp, collision and reset behaviour.
module tb_servo_pwm_driver;
  logic clk, rst_n;
  logic [8:0] ba0, aa0, ba1, aa1, ba2, aa2;
  logic cv0, cv1, cv2;
  logic bp0, ap0, st0, bp1, ap1, st1, bp2, ap2, st2;
  logic [8:0] bc0, ac0, bc1, ac1, bc2, ac2;
  logic [5:0] pw;
  int hi[6], wid[6];
  int per2, pc2, cyc, total, bad;
  logic prev2;
  servo_pwm_driver #(.TICKS_PER_US(1), .PERIOD_US(2500), .SLEW_DEG(5)) u0 (
    .clk(clk), .rst_n(rst_n), .base_angle(ba0), .arm_angle(aa0), .cmd_valid(cv0),
    .base_pwm(bp0), .arm_pwm(ap0), .base_cur(bc0), .arm_cur(ac0), .settled(st0));
  servo_pwm_driver #(.TICKS_PER_US(1), .PERIOD_US(2500), .SLEW_DEG(0)) u1 (
    .clk(clk), .rst_n(rst_n), .base_angle(ba1), .arm_angle(aa1), .cmd_valid(cv1),
    .base_pwm(bp1), .arm_pwm(ap1), .base_cur(bc1), .arm_cur(ac1), .settled(st1));
  servo_pwm_driver #(.TICKS_PER_US(2), .PERIOD_US(2500), .SLEW_DEG(5)) u2 (
    .clk(clk), .rst_n(rst_n), .base_angle(ba2), .arm_angle(aa2), .cmd_valid(cv2),
    .base_pwm(bp2), .arm_pwm(ap2), .base_cur(bc2), .arm_cur(ac2), .settled(st2));
  assign pw = {ap2, bp2, ap1, bp1, ap0, bp0};
  initial clk = 1'b0;
  always #5 clk = ~clk;
  initial begin
    for (int i = 0; i < 6; i++) begin
      hi[i] = 0;
      wid[i] = 0;
    end
    per2 = 0;
    pc2 = 0;
    prev2 = 1'b0;
  end
  always @(negedge clk) begin
    for (int i = 0; i < 6; i++)
      if (pw[i]) hi[i] <= hi[i] + 1;
      else if (hi[i] != 0) begin
        wid[i] <= hi[i];
        hi[i] <= 0;
      end
    if (bp2 && !prev2) begin
      per2 <= pc2;
      pc2 <= 1;
    end else pc2 <= pc2 + 1;
    prev2 <= bp2;
  end
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s cyc=%0d got=%0d exp=%0d", tag, cyc, got, exp);
    end
  endtask
  task automatic tick();
    @(negedge clk);
    cyc++;
  endtask
  task automatic goto_cyc(input int p);
    while (cyc < p) tick();
  endtask
  initial begin
    total = 0;
    bad = 0;
    cyc = 0;
    rst_n = 1'b0;
    {ba0, aa0, ba1, aa1, ba2, aa2} = '0;
    {cv0, cv1, cv2} = '0;
    repeat (3) @(negedge clk);
    chk("rst_bpwm", bp0, 0);
    chk("rst_apwm", ap0, 0);
    chk("rst_bcur", bc0, 90);
    chk("rst_acur", ac0, 90);
    chk("rst_settled", st0, 0);
    rst_n = 1'b1;
    @(negedge clk);
    cyc = 0;
    chk("start_bpwm", bp0, 1);
    chk("start_apwm", ap0, 1);
    goto_cyc(1499);
    chk("last_hi", bp0, 1);
    tick();
    chk("first_lo", bp0, 0);
    goto_cyc(1502);
    chk("home_bw", wid[0], 1500);
    chk("home_aw", wid[1], 1500);
    goto_cyc(2499);
    chk("pre_fe_settled", st0, 0);
    tick();
    chk("home_settled", st0, 1);
    goto_cyc(3000);
    {cv0, ba0, aa0} = {1'b1, 9'd90, 9'd90};
    tick();
    cv0 = 1'b0;
    chk("same_cmd_settled", st0, 1);
    goto_cyc(3002);
    chk("tick2_width", wid[4], 3000);
    goto_cyc(4999);
    chk("tick2_pre_settled", st2, 0);
    {cv0, ba0, aa0} = {1'b1, 9'd100, 9'd90};
    tick();
    cv0 = 1'b0;
    chk("coll_bcur", bc0, 90);
    chk("coll_settled", st0, 0);
    chk("tick2_settled", st2, 1);
    goto_cyc(5002);
    chk("tick2_period", per2, 5000);
    goto_cyc(5500);
    {cv0, ba0, aa0} = {1'b1, 9'd120, 9'd30};
    tick();
    aa0 = 9'd150;
    tick();
    cv0 = 1'b0;
    goto_cyc(7500);
    chk("coll_next_bcur", bc0, 95);
    chk("b2b_acur", ac0, 95);
    goto_cyc(9052);
    chk("b95_width", wid[0], 1550);
    chk("a95_width", wid[1], 1550);
    goto_cyc(20000);
    chk("pre_rst_bcur", bc0, 120);
    chk("pre_rst_acur", ac0, 120);
    goto_cyc(20700);
    chk("mid_pulse_hi", bp0, 1);
    rst_n = 1'b0;
    tick();
    chk("mid_rst_bpwm", bp0, 0);
    chk("mid_rst_apwm", ap0, 0);
    chk("mid_rst_bcur", bc0, 90);
    chk("mid_rst_settled", st0, 0);
    tick();
    tick();
    rst_n = 1'b1;
    tick();
    cyc = 0;
    chk("rerun_bpwm", bp0, 1);
    chk("rerun_acur", ac0, 90);
    goto_cyc(1502);
    chk("rerun_bw", wid[0], 1500);
    goto_cyc(2500);
    chk("rerun_settled", st0, 1);
    chk("ns_home_settled", st1, 1);
    goto_cyc(3000);
    {cv0, ba0, aa0} = {1'b1, 9'd0, 9'd180};
    {cv1, ba1, aa1} = {1'b1, 9'd200, 9'd0};
    tick();
    {cv0, cv1} = 2'b00;
    chk("slew_cmd_settled", st0, 0);
    chk("ns_cmd_settled", st1, 0);
    goto_cyc(4502);
    chk("frame_unchanged_bw", wid[0], 1500);
    for (int k = 1; k <= 18; k++) begin
      goto_cyc(2500 * (k + 1));
      chk("slew_bcur", bc0, 90 - 5 * k);
      chk("slew_acur", ac0, 90 + 5 * k);
      if (k == 1) begin
        chk("ns_bcur", bc1, 180);
        chk("ns_acur", ac1, 0);
        chk("ns_settled0", st1, 0);
        goto_cyc(7402);
        chk("ns_bw", wid[2], 2400);
        chk("ns_aw", wid[3], 600);
      end
      if (k == 2) chk("ns_settled1", st1, 1);
    end
    chk("slew_end_settled", st0, 0);
    goto_cyc(50000);
    chk("slew_settled", st0, 1);
    goto_cyc(52402);
    chk("slew_bw", wid[0], 600);
    chk("slew_aw", wid[1], 2400);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
